// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe referee: cell codes, referee states and the
// table of the eight winning lines.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam int LAST_CELL = 8;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    READY = 2'd0,
    EVAL  = 2'd1,
    DONE  = 2'd2
  } referee_state_t;

  // Rows, then columns, then the two diagonals; entries are row-major cell indices.
  localparam int WIN_LINES [NUM_LINES][3] = '{
    '{0, 1, 2},
    '{3, 4, 5},
    '{6, 7, 8},
    '{0, 3, 6},
    '{1, 4, 7},
    '{2, 5, 8},
    '{0, 4, 8},
    '{2, 4, 6}
  };

  function automatic logic [1:0] cell_at(input logic [17:0] packed_board, input int idx);
    return packed_board[2*idx +: 2];
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational scan of the eight winning lines; reports whether any line holds three
// identical non-empty cells and which player owns it.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  output logic        line_win,
  output logic [1:0]  line_winner
);

  logic [1:0] cell_a;
  logic [1:0] cell_b;
  logic [1:0] cell_c;

  // The first complete line found wins; in legal play only one player can own a line.
  always_comb begin
    line_win    = 1'b0;
    line_winner = CELL_EMPTY;
    cell_a      = CELL_EMPTY;
    cell_b      = CELL_EMPTY;
    cell_c      = CELL_EMPTY;
    for (int l = 0; l < NUM_LINES; l++) begin
      cell_a = cell_at(board, WIN_LINES[l][0]);
      cell_b = cell_at(board, WIN_LINES[l][1]);
      cell_c = cell_at(board, WIN_LINES[l][2]);
      if (!line_win && cell_a != CELL_EMPTY && cell_a == cell_b && cell_b == cell_c) begin
        line_win    = 1'b1;
        line_winner = cell_a;
      end
    end
  end

endmodule

// File: rtl/ttt_board_referee.sv
// Tic-tac-toe board store and referee: accepts move strobes, rejects illegal moves and
// reports win / full board. Optional macro TTT_MOVE_COUNT_EN adds move_count and last_position.
module ttt_board_referee
  import ttt_pkg::*;
#(
  parameter int CELLS = 9,
  parameter int POS_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             player1_play,
  input  logic             player2_play,
  input  logic [POS_W-1:0] position,
  output logic             illegal,
  output logic             move_done,
  output logic             win,
  output logic [1:0]       winner,
  output logic             no_space,
`ifdef TTT_MOVE_COUNT_EN
  output logic [3:0]       move_count,
  output logic [3:0]       last_position,
`endif
  output logic [17:0]      board
);

  referee_state_t state_q, state_d;

  logic [17:0] board_q, board_d;
  logic        illegal_q, illegal_d;
  logic        move_done_q, move_done_d;
  logic        win_q, win_d;
  logic [1:0]  winner_q, winner_d;
  logic        no_space_q, no_space_d;

  logic        one_req;
  logic        both_req;
  logic        pos_ok;
  logic [1:0]  target_cell;
  logic [1:0]  player_code;
  logic        legal_req;
  logic        illegal_req;
  logic        line_win;
  logic [1:0]  line_winner;
  logic        board_full;

  assign one_req     = player1_play ^ player2_play;
  assign both_req    = player1_play & player2_play;
  assign player_code = player1_play ? CELL_X : CELL_O;

  // Out-of-range positions never match a cell, so they leave pos_ok low.
  always_comb begin
    pos_ok      = 1'b0;
    target_cell = CELL_EMPTY;
    for (int i = 0; i < CELLS; i++) begin
      if (position == POS_W'(i)) begin
        pos_ok      = 1'b1;
        target_cell = cell_at(board_q, i);
      end
    end
  end

  assign legal_req   = one_req && pos_ok && (target_cell == CELL_EMPTY);
  assign illegal_req = both_req || (one_req && !legal_req);

  ttt_line_check u_line_check (
    .board       (board_q),
    .line_win    (line_win),
    .line_winner (line_winner)
  );

  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      if (cell_at(board_q, i) == CELL_EMPTY) begin
        board_full = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= READY;
      board_q     <= '0;
      illegal_q   <= 1'b0;
      move_done_q <= 1'b0;
      win_q       <= 1'b0;
      winner_q    <= CELL_EMPTY;
      no_space_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      illegal_q   <= illegal_d;
      move_done_q <= move_done_d;
      win_q       <= win_d;
      winner_q    <= winner_d;
      no_space_q  <= no_space_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:   if (legal_req) state_d = EVAL;
      EVAL:    state_d = (line_win || board_full) ? DONE : READY;
      DONE:    state_d = DONE;
      default: state_d = READY;
    endcase
  end

  // Registered-output next values; strobes only matter while READY.
  always_comb begin
    board_d     = board_q;
    illegal_d   = 1'b0;
    move_done_d = 1'b0;
    win_d       = win_q;
    winner_d    = winner_q;
    no_space_d  = no_space_q;
    case (state_q)
      READY: begin
        if (legal_req) begin
          for (int i = 0; i < CELLS; i++) begin
            if (position == POS_W'(i)) begin
              board_d[2*i +: 2] = player_code;
            end
          end
        end else if (illegal_req) begin
          illegal_d = 1'b1;
        end
      end
      EVAL: begin
        move_done_d = 1'b1;
        win_d       = line_win;
        winner_d    = line_winner;
        no_space_d  = board_full;
      end
      default: ;
    endcase
  end

  assign board     = board_q;
  assign illegal   = illegal_q;
  assign move_done = move_done_q;
  assign win       = win_q;
  assign winner    = winner_q;
  assign no_space  = no_space_q;

`ifdef TTT_MOVE_COUNT_EN
  logic [3:0] move_count_q;
  logic [3:0] last_position_q;

  // Counts accepted moves on the same edge that writes the board.
  always_ff @(posedge clock) begin
    if (reset) begin
      move_count_q    <= 4'd0;
      last_position_q <= 4'hF;
    end else if (state_q == READY && legal_req) begin
      if (move_count_q != 4'd9) begin
        move_count_q <= move_count_q + 4'd1;
      end
      last_position_q <= 4'(position);
    end
  end

  assign move_count    = move_count_q;
  assign last_position = last_position_q;
`endif

endmodule

// File: tb/tb_ttt_board_referee.sv
// Self-checking bench for ttt_board_referee: directed games plus randomized play, all
// compared every cycle against a cell-array model of the game rules.
module tb_ttt_board_referee;

  logic        clock;
  logic        reset;
  logic        player1_play;
  logic        player2_play;
  logic [3:0]  position;
  logic        illegal;
  logic        move_done;
  logic        win;
  logic [1:0]  winner;
  logic        no_space;
  logic [17:0] board;
`ifdef TTT_MOVE_COUNT_EN
  logic [3:0]  move_count;
  logic [3:0]  last_position;
`endif

  int checks;
  int failures;

  int   mb [9];
  int   phase;
  logic exp_illegal;
  logic exp_done;
  logic exp_win;
  int   exp_winner;
  logic exp_full;
  int   exp_count;
  int   exp_last;

  ttt_board_referee dut (
    .clock         (clock),
    .reset         (reset),
    .player1_play  (player1_play),
    .player2_play  (player2_play),
    .position      (position),
    .illegal       (illegal),
    .move_done     (move_done),
    .win           (win),
    .winner        (winner),
    .no_space      (no_space),
`ifdef TTT_MOVE_COUNT_EN
    .move_count    (move_count),
    .last_position (last_position),
`endif
    .board         (board)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [17:0] packBoard();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mb[i]);
    return b;
  endfunction

  // Owner (1 = X, 2 = O) of any completed row, column or diagonal, else 0.
  function automatic int lineOwner();
    int w;
    w = 0;
    for (int k = 0; k < 3; k++) begin
      if (mb[3*k] != 0 && mb[3*k] == mb[3*k+1] && mb[3*k] == mb[3*k+2]) w = mb[3*k];
      if (mb[k] != 0 && mb[k] == mb[k+3] && mb[k] == mb[k+6]) w = mb[k];
    end
    if (mb[4] != 0 && mb[0] == mb[4] && mb[4] == mb[8]) w = mb[4];
    if (mb[4] != 0 && mb[2] == mb[4] && mb[4] == mb[6]) w = mb[4];
    return w;
  endfunction

  function automatic int filledCells();
    int n;
    n = 0;
    for (int i = 0; i < 9; i++) if (mb[i] != 0) n++;
    return n;
  endfunction

  // Phase 0 = accepting moves, 1 = evaluating last move, 2 = game over.
  task automatic modelStep(input logic p1, input logic p2, input int pos, input logic rst);
    exp_illegal = 1'b0;
    exp_done    = 1'b0;
    if (rst) begin
      for (int i = 0; i < 9; i++) mb[i] = 0;
      phase = 0; exp_win = 0; exp_winner = 0; exp_full = 0;
      exp_count = 0; exp_last = 15;
    end else if (phase == 0) begin
      if (p1 && p2) exp_illegal = 1'b1;
      else if (p1 || p2) begin
        if (pos <= 8 && mb[pos] == 0) begin
          mb[pos] = p1 ? 1 : 2;
          phase = 1;
          if (exp_count < 9) exp_count++;
          exp_last = pos;
        end else exp_illegal = 1'b1;
      end
    end else if (phase == 1) begin
      exp_done   = 1'b1;
      exp_winner = lineOwner();
      exp_win    = (exp_winner != 0);
      exp_full   = (filledCells() == 9);
      phase      = (exp_win || exp_full) ? 2 : 0;
    end
  endtask

  task automatic applyStimulus(input logic p1, input logic p2, input int pos, input logic rst);
    @(negedge clock);
    reset        = rst;
    player1_play = p1;
    player2_play = p2;
    position     = 4'(pos);
    @(posedge clock);
    #1;
    modelStep(p1, p2, pos, rst);
    checkOutput("board", 32'(board), 32'(packBoard()));
    checkOutput("illegal", 32'(illegal), 32'(exp_illegal));
    checkOutput("move_done", 32'(move_done), 32'(exp_done));
    checkOutput("win", 32'(win), 32'(exp_win));
    checkOutput("winner", 32'(winner), 32'(exp_winner));
    checkOutput("no_space", 32'(no_space), 32'(exp_full));
`ifdef TTT_MOVE_COUNT_EN
    checkOutput("move_count", 32'(move_count), 32'(exp_count));
    checkOutput("last_position", 32'(last_position), 32'(exp_last));
`endif
  endtask

  task automatic playMove(input int player, input int pos);
    applyStimulus(player == 1, player == 2, pos, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int seq_x [5];
    int fill [9];
    checks = 0; failures = 0;
    reset = 1'b1; player1_play = 1'b0; player2_play = 1'b0; position = '0;

    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkOutput("reset_board", 32'(board), 32'd0);

    // X to the centre, then two rejected requests.
    applyStimulus(1'b1, 1'b0, 4, 1'b0);
    checkOutput("x4_cell", 32'(board[9:8]), 32'd1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("x4_done", 32'(move_done), 32'd1);
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("occupied_illegal", 32'(illegal), 32'd0);
    applyStimulus(1'b1, 1'b0, 9, 1'b0);
    checkOutput("range_illegal", 32'(illegal), 32'd1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);

    // Top row win for X, then a move after the game ends.
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    seq_x = '{0, 3, 1, 4, 2};
    for (int i = 0; i < 5; i++) playMove((i % 2) + 1, seq_x[i]);
    checkOutput("row_win", 32'(win), 32'd1);
    checkOutput("row_winner", 32'(winner), 32'd1);
    applyStimulus(1'b0, 1'b1, 5, 1'b0);
    checkOutput("done_ignore", 32'(board[11:10]), 32'd0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);

    // Drawn game fills the board.
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    fill = '{1, 2, 1, 1, 2, 1, 2, 1, 2};
    for (int i = 0; i < 9; i++) playMove(fill[i], i);
    checkOutput("draw_full", 32'(no_space), 32'd1);
    checkOutput("draw_nowin", 32'(win), 32'd0);

    // Simultaneous strobes, then reset during evaluation.
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    checkOutput("both_illegal", 32'(illegal), 32'd1);
    applyStimulus(1'b1, 1'b0, 2, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkOutput("eval_reset_board", 32'(board), 32'd0);
    checkOutput("eval_reset_done", 32'(move_done), 32'd0);

    // Randomized games with occasional mid-game reset.
    for (int g = 0; g < 60; g++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1);
      for (int c = 0; c < 40; c++) begin
        int r;
        int pos;
        r   = int'($urandom_range(0, 99));
        pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
        if ($urandom_range(0, 59) == 0)
          applyStimulus(1'b0, 1'b0, 0, 1'b1);
        else if (r < 8)  applyStimulus(1'b1, 1'b1, pos, 1'b0);
        else if (r < 50) applyStimulus(1'b1, 1'b0, pos, 1'b0);
        else if (r < 90) applyStimulus(1'b0, 1'b1, pos, 1'b0);
        else             applyStimulus(1'b0, 1'b0, pos, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
